cfg_reg_file: RTL and testbench

CFG_REG_FILE -- requirements
Module: cfg_reg_file

---
 rtl/cfg_reg_file.sv | 169 ++++++++++++++++
 tb/tb_cfg_reg_file.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_reg_file.sv
// rtl/cfg_reg_file.sv - SPI-fed PID config registers: shadow/active banks, commit, soft reset, sticky errors.
// Optional even-parity check over the captured frame is compiled in with CFG_PARITY_EN.
module cfg_reg_file #(
    parameter int WORD_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs,
    input  logic                 busy,
    input  logic [WORD_BITS-1:0] word_in,
    output logic [7:0]           sp,
    output logic [7:0]           kp,
    output logic [7:0]           ki,
    output logic [7:0]           kd,
    output logic                 update,
    output logic [2:0]           err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_APPLY  = 2'd2
    } state_t;

    localparam logic [3:0] CMD_NOP    = 4'h0;
    localparam logic [3:0] CMD_SP     = 4'h1;
    localparam logic [3:0] CMD_KP     = 4'h2;
    localparam logic [3:0] CMD_KI     = 4'h3;
    localparam logic [3:0] CMD_KD     = 4'h4;
    localparam logic [3:0] CMD_COMMIT = 4'h8;
    localparam logic [3:0] CMD_CLRERR = 4'h9;
    localparam logic [3:0] CMD_SRST   = 4'hF;

    localparam logic [7:0] RST_SP = 8'h00;
    localparam logic [7:0] RST_KP = 8'h01;
    localparam logic [7:0] RST_KI = 8'h00;
    localparam logic [7:0] RST_KD = 8'h00;

    state_t               r_state;
    state_t               w_next;
    logic                 r_busy_q;
    logic [WORD_BITS-1:0] r_cap;
    logic [7:0]           r_sh_sp, r_sh_kp, r_sh_ki, r_sh_kd;
    logic [7:0]           r_sp, r_kp, r_ki, r_kd;
    logic                 r_update;
    logic [2:0]           r_err;

    logic                 w_frame_done;
    logic [3:0]           w_cmd;
    logic [7:0]           w_data;
    logic                 w_parity_ok;
    logic                 w_exec;
    logic                 w_legal;
    logic [2:0]           w_err_set;
    logic                 w_err_clr;

    assign w_frame_done = r_busy_q & ~busy & ~cs;
    assign w_cmd        = r_cap[15:12];
    assign w_data       = r_cap[7:0];

`ifdef CFG_PARITY_EN
    assign w_parity_ok = ~(^r_cap[15:0]);
`else
    assign w_parity_ok = 1'b1;
`endif

    assign w_exec = (r_state == S_DECODE) && w_parity_ok;

    always_comb begin
        w_legal = 1'b0;
        case (w_cmd)
            CMD_NOP, CMD_SP, CMD_KP, CMD_KI, CMD_KD,
            CMD_COMMIT, CMD_CLRERR, CMD_SRST: w_legal = 1'b1;
            default:                          w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_frame_done) w_next = S_DECODE;
            S_DECODE: begin
                if (w_parity_ok && (w_cmd == CMD_COMMIT || w_cmd == CMD_SRST))
                    w_next = S_APPLY;
                else
                    w_next = S_IDLE;
            end
            S_APPLY:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // A frame landing outside IDLE is dropped and flagged as an overrun.
    always_comb begin
        w_err_set    = 3'b000;
        w_err_set[0] = w_exec && !w_legal;
`ifdef CFG_PARITY_EN
        w_err_set[1] = (r_state == S_DECODE) && !w_parity_ok;
`endif
        w_err_set[2] = w_frame_done && (r_state != S_IDLE);
        w_err_clr    = w_exec && (w_cmd == CMD_CLRERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_busy_q <= 1'b0;
            r_cap    <= '0;
            r_err    <= 3'b000;
            r_update <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_busy_q <= busy;
            r_update <= (r_state == S_APPLY);
            if (r_state == S_IDLE && w_frame_done)
                r_cap <= word_in;
            // Clearing wins over any flag raised in the same cycle.
            if (w_err_clr)
                r_err <= 3'b000;
            else
                r_err <= r_err | w_err_set;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_sp <= RST_SP;
            r_sh_kp <= RST_KP;
            r_sh_ki <= RST_KI;
            r_sh_kd <= RST_KD;
            r_sp    <= RST_SP;
            r_kp    <= RST_KP;
            r_ki    <= RST_KI;
            r_kd    <= RST_KD;
        end else if (w_exec) begin
            case (w_cmd)
                CMD_SP:  r_sh_sp <= w_data;
                CMD_KP:  r_sh_kp <= w_data;
                CMD_KI:  r_sh_ki <= w_data;
                CMD_KD:  r_sh_kd <= w_data;
                default: ;
            endcase
        end else if (r_state == S_APPLY) begin
            if (w_cmd == CMD_COMMIT) begin
                r_sp <= r_sh_sp;
                r_kp <= r_sh_kp;
                r_ki <= r_sh_ki;
                r_kd <= r_sh_kd;
            end else begin
                r_sh_sp <= RST_SP;
                r_sh_kp <= RST_KP;
                r_sh_ki <= RST_KI;
                r_sh_kd <= RST_KD;
                r_sp    <= RST_SP;
                r_kp    <= RST_KP;
                r_ki    <= RST_KI;
                r_kd    <= RST_KD;
            end
        end
    end

    assign sp     = r_sp;
    assign kp     = r_kp;
    assign ki     = r_ki;
    assign kd     = r_kd;
    assign update = r_update;
    assign err    = r_err;

endmodule

// File: tb/tb_cfg_reg_file.sv
// tb/tb_cfg_reg_file.sv - randomized self-checking bench for cfg_reg_file against a command-level model.
module tb_cfg_reg_file;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b1;
    logic        busy = 1'b0;
    logic [15:0] word_in = 16'h0000;
    logic [7:0]  sp, kp, ki, kd;
    logic        update;
    logic [2:0]  err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_sh  [4];
    logic [7:0] m_act [4];
    logic [2:0] m_err;

    cfg_reg_file #(.WORD_BITS(16)) dut (
        .clk(clk), .reset(reset), .cs(cs), .busy(busy), .word_in(word_in),
        .sp(sp), .kp(kp), .ki(ki), .kd(kd), .update(update), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dut_act();
        return {sp, kp, ki, kd};
    endfunction

    function automatic logic [31:0] pack(input logic [7:0] a [4]);
        return {a[0], a[1], a[2], a[3]};
    endfunction

    task automatic model_reset();
        m_sh[0] = 8'h00; m_sh[1] = 8'h01; m_sh[2] = 8'h00; m_sh[3] = 8'h00;
        m_act = m_sh;
        m_err = 3'b000;
    endtask

    // Returns 1 when the frame causes a register transfer (commit or soft reset).
    function automatic bit model_frame(input logic [15:0] w);
        logic [3:0] c;
        c = w[15:12];
`ifdef CFG_PARITY_EN
        if (^w) begin
            m_err[1] = 1'b1;
            return 1'b0;
        end
`endif
        if (c >= 4'h1 && c <= 4'h4) begin
            m_sh[c - 4'h1] = w[7:0];
            return 1'b0;
        end
        if (c == 4'h0) return 1'b0;
        if (c == 4'h8) begin
            m_act = m_sh;
            return 1'b1;
        end
        if (c == 4'h9) begin
            m_err = 3'b000;
            return 1'b0;
        end
        if (c == 4'hF) begin
            m_sh[0] = 8'h00; m_sh[1] = 8'h01; m_sh[2] = 8'h00; m_sh[3] = 8'h00;
            m_act = m_sh;
            return 1'b1;
        end
        m_err[0] = 1'b1;
        return 1'b0;
    endfunction

    task automatic start_frame();
        @(posedge clk); #1;
        cs = 1'b0;
        busy = 1'b1;
        word_in = 16'($urandom);
        repeat ($urandom_range(1, 3)) begin
            @(posedge clk); #1;
        end
    endtask

    // Ends a frame (cycle 0 = frame-done) and tracks update/active over the following cycles.
    task automatic run_frame(input logic [15:0] w, input bit abort);
        logic [31:0] old_act;
        bit          xfer;
        start_frame();
        old_act = pack(m_act);
        xfer = abort ? 1'b0 : model_frame(w);
        word_in = w;
        busy = 1'b0;
        if (abort) cs = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            cs = 1'b0;
            @(negedge clk);
            n_tests++;
            if (update !== (xfer && c == 3)) begin
                n_fail++;
                $display("FAIL update w=%h cyc=%0d got %b want %b", w, c, update, xfer && c == 3);
            end
            n_tests++;
            if (dut_act() !== ((c < 3) ? old_act : pack(m_act))) begin
                n_fail++;
                $display("FAIL active w=%h cyc=%0d got %h want %h", w, c, dut_act(),
                         (c < 3) ? old_act : pack(m_act));
            end
        end
        n_tests++;
        if (err !== m_err) begin
            n_fail++;
            $display("FAIL err w=%h got %b want %b", w, err, m_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        n_tests++;
        if ({dut_act(), err, update} !== {pack(m_act), 3'b000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_hold got %h/%b/%b want %h/000/0", dut_act(), err, update, pack(m_act));
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({dut_act(), err, update} !== {32'h00010000, 3'b000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_vals got %h/%b/%b want 00010000/000/0", dut_act(), err, update);
        end
    endtask

    task automatic test_commit();
        run_frame(16'h1040, 1'b0);
        run_frame(16'h2005, 1'b0);
        run_frame(16'h8000, 1'b0);
        n_tests++;
        if ({sp, kp} !== 16'h4005) begin
            n_fail++;
            $display("FAIL commit_vals got %h want 4005", {sp, kp});
        end
    endtask

    task automatic test_illegal();
        run_frame(16'h7012, 1'b0);
        n_tests++;
        if (err !== 3'b001) begin
            n_fail++;
            $display("FAIL illegal_err got %b want 001", err);
        end
        run_frame(16'h9000, 1'b0);
        n_tests++;
        if (err !== 3'b000) begin
            n_fail++;
            $display("FAIL clear_err got %b want 000", err);
        end
    endtask

    task automatic test_abort();
        run_frame(16'h7055, 1'b1);
        run_frame(16'h8000, 1'b1);
        n_tests++;
        if (err !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_err got %b want 000", err);
        end
    endtask

    task automatic test_soft_reset();
        run_frame(16'h1033, 1'b0);
        run_frame(16'h8000, 1'b0);
        n_tests++;
        if (sp !== 8'h33) begin
            n_fail++;
            $display("FAIL pre_srst_sp got %h want 33", sp);
        end
        run_frame(16'hF000, 1'b0);
        n_tests++;
        if (dut_act() !== 32'h00010000) begin
            n_fail++;
            $display("FAIL srst_vals got %h want 00010000", dut_act());
        end
        run_frame(16'h8000, 1'b0);
        n_tests++;
        if (dut_act() !== 32'h00010000) begin
            n_fail++;
            $display("FAIL srst_shadow got %h want 00010000", dut_act());
        end
    endtask

    task automatic test_parity();
        run_frame(16'h1140, 1'b0);
        run_frame(16'h8000, 1'b0);
`ifdef CFG_PARITY_EN
        n_tests++;
        if (err[1] !== 1'b1 || sp !== 8'h00) begin
            n_fail++;
            $display("FAIL parity_reject got err=%b sp=%h want err[1]=1 sp=00", err, sp);
        end
`else
        n_tests++;
        if (sp !== 8'h40 || err[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_off got err=%b sp=%h want err[1]=0 sp=40", err, sp);
        end
`endif
        run_frame(16'h9000, 1'b0);
    endtask

    // Second frame ends while the commit is still in APPLY and must be dropped.
    task automatic test_back_to_back();
        logic [31:0] old_act;
        bit          seen_upd;
        run_frame(16'h1011, 1'b0);
        start_frame();
        old_act = pack(m_act);
        void'(model_frame(16'h8000));
        m_err[2] = 1'b1;
        word_in = 16'h8000;
        busy = 1'b0;
        @(posedge clk); #1;
        busy = 1'b1;
        @(posedge clk); #1;
        busy = 1'b0;
        word_in = 16'h1077;
        seen_upd = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            if (c == 3) seen_upd = update;
            else if (update) seen_upd = 1'b0;
            @(posedge clk); #1;
        end
        n_tests++;
        if (seen_upd !== 1'b1 || dut_act() !== pack(m_act) || dut_act() === old_act) begin
            n_fail++;
            $display("FAIL b2b_commit upd=%b got %h want %h", seen_upd, dut_act(), pack(m_act));
        end
        n_tests++;
        if (err !== m_err) begin
            n_fail++;
            $display("FAIL b2b_overrun got %b want %b", err, m_err);
        end
        run_frame(16'h8000, 1'b0);
        n_tests++;
        if (sp !== 8'h11) begin
            n_fail++;
            $display("FAIL b2b_dropped sp got %h want 11", sp);
        end
        run_frame(16'h9000, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        run_frame(16'h1022, 1'b0);
        start_frame();
        #2 reset = 1'b1;
        model_reset();
        #1 busy = 1'b0;
        word_in = 16'h8000;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({dut_act(), err, update} !== {32'h00010000, 3'b000, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid got %h/%b/%b want 00010000/000/0", dut_act(), err, update);
        end
        run_frame(16'h4099, 1'b0);
        run_frame(16'h8000, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0]  c;
        logic [15:0] w;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: c = 4'($urandom_range(1, 4));
                4, 5:       c = 4'h8;
                6:          c = 4'h9;
                7:          c = 4'hF;
                default:    c = 4'($urandom);
            endcase
            w = {c, 4'($urandom), 8'($urandom)};
            run_frame(w, ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_illegal();
        test_abort();
        test_soft_reset();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
